// File: rtl/program_loader_rom.sv
// Program loader and instruction store: assembles a byte-serial program into 16-bit
// words, holds the CPU in reset while loading and serves fetches combinationally.
module program_loader_rom #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  output logic              load_ready,
  output logic              load_done,
  output logic              cpu_rst,
  input  logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_value
);

  localparam int DEPTH = 2 ** ADDR_W;
  // Counters must be able to hold a full-array count (256 words for a zero length byte).
  localparam int CNT_W = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;

  typedef enum logic [2:0] {IDLE, LEN, LOW, HIGH, RUN} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  target_q, target_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]        low_q, low_d;
  logic              done_q, done_d;
  logic              accept;
  logic              mem_we;
  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    low_d      = low_q;
    done_d     = 1'b0;
    mem_we     = 1'b0;
    load_ready = (state_q == LEN) || (state_q == LOW) || (state_q == HIGH);
    accept     = load_valid && load_ready && !load_start;

    // load_start wins over any byte presented in the same cycle
    if (load_start) begin
      state_d  = LEN;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (accept) begin
      case (state_q)
        LEN: begin
          target_d = (load_byte == 8'h00) ? CNT_W'(256) : CNT_W'(load_byte);
          wr_ptr_d = '0;
          count_d  = '0;
          state_d  = LOW;
        end
        LOW: begin
          low_d   = load_byte;
          state_d = HIGH;
        end
        HIGH: begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_q + CNT_W'(1);
          if (count_q + CNT_W'(1) == target_q) begin
            done_d  = 1'b1;
            state_d = RUN;
          end else begin
            state_d = LOW;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      target_q <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      low_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      low_q    <= low_d;
      done_q   <= done_d;
    end
  end

  // Storage is deliberately not reset; only words below count_q are ever exposed.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= DATA_W'({load_byte, low_q});
    end
  end

  always_comb begin
    cpu_rst   = (state_q != RUN);
    load_done = done_q;
    mem_value = '0;
    if ((state_q == RUN) && (CNT_W'(mem_address) < count_q)) begin
      mem_value = mem[mem_address];
    end
  end

endmodule

// File: tb/tb_program_loader_rom.sv
// Directed bench for program_loader_rom: a byte-level load model checked every cycle,
// plus literal expectations for reset, latency, readback and restart scenarios.
module tb_program_loader_rom;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_ready;
  logic        load_done;
  logic        cpu_rst;
  logic [7:0]  mem_address;
  logic [15:0] mem_value;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  program_loader_rom #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
    .load_byte(load_byte), .load_ready(load_ready), .load_done(load_done),
    .cpu_rst(cpu_rst), .mem_address(mem_address), .mem_value(mem_value)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tracks the load in terms of bytes received rather than states.
  logic [15:0] exp_mem [256];
  bit          m_loading = 1'b0;
  bit          m_run     = 1'b0;
  bit          m_len     = 1'b0;
  bit          m_done    = 1'b0;
  int          m_nbytes  = 0;
  int          m_target  = 0;
  int          m_words   = 0;
  logic [7:0]  m_low     = 8'h00;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_loading <= 1'b0;
      m_run     <= 1'b0;
      m_len     <= 1'b0;
      m_done    <= 1'b0;
      m_nbytes  <= 0;
    end else begin
      m_done <= 1'b0;
      if (load_start) begin
        m_loading <= 1'b1;
        m_run     <= 1'b0;
        m_len     <= 1'b0;
        m_nbytes  <= 0;
      end else if (m_loading && load_valid) begin
        if (!m_len) begin
          m_target <= (load_byte == 8'h00) ? 256 : int'(load_byte);
          m_len    <= 1'b1;
          m_nbytes <= 0;
        end else if (m_nbytes % 2 == 0) begin
          m_low    <= load_byte;
          m_nbytes <= m_nbytes + 1;
        end else begin
          exp_mem[m_nbytes / 2] <= {load_byte, m_low};
          m_nbytes <= m_nbytes + 1;
          if ((m_nbytes + 1) / 2 == m_target) begin
            m_loading <= 1'b0;
            m_run     <= 1'b1;
            m_done    <= 1'b1;
            m_words   <= m_target;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] ev;
    ev = (m_run && int'(mem_address) < m_words) ? exp_mem[mem_address] : 16'h0000;
    chk("cyc_cpu_rst", 32'(cpu_rst), 32'(!m_run));
    chk("cyc_load_ready", 32'(load_ready), 32'(m_loading));
    chk("cyc_load_done", 32'(load_done), 32'(m_done));
    chk("cyc_mem_value", 32'(mem_value), 32'(ev));
    if (load_done === 1'b1) done_cnt++;
  end

  task automatic drive(input logic s, input logic v, input logic [7:0] b);
    load_start = s;
    load_valid = v;
    load_byte  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] a, input logic [15:0] exp, input string name);
    mem_address = a;
    #1;
    chk(name, 32'(mem_value), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  logic [7:0] prog [5];
  int d0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    prog[0] = 8'h02; prog[1] = 8'h02; prog[2] = 8'h05; prog[3] = 8'h03; prog[4] = 8'h00;
    rst = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_byte = 8'h00; mem_address = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_load_ready", 32'(load_ready), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_mem_value", 32'(mem_value), 32'd0);
    rst = 1'b1;
    drive(1'b0, 1'b1, 8'h33);
    chk("idle_ready", 32'(load_ready), 32'd0);

    // back-to-back 2-word load
    d0 = done_cnt;
    drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) chk("t2_cpu_rst_before", 32'(cpu_rst), 32'd1);
      drive(1'b0, 1'b1, prog[i]);
    end
    chk("t2_done", 32'(load_done), 32'd1);
    chk("t2_cpu_rst", 32'(cpu_rst), 32'd0);
    drive(1'b0, 1'b1, 8'h77);
    chk("t2_done_once", 32'(done_cnt - d0), 32'd1);
    rd(8'd0, 16'h0502, "t2_rd0");
    rd(8'd1, 16'h0003, "t2_rd1");
    rd(8'd2, 16'h0000, "t2_rd2");

    // same load, valid toggling
    d0 = done_cnt;
    drive(1'b1, 1'b0, 8'h00);
    chk("t3_reload_cpu_rst", 32'(cpu_rst), 32'd1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, prog[i]);
      if (i < 4) drive(1'b0, 1'b0, 8'h5A);
    end
    chk("t3_done", 32'(load_done), 32'd1);
    drive(1'b0, 1'b0, 8'h00);
    chk("t3_done_once", 32'(done_cnt - d0), 32'd1);
    rd(8'd0, 16'h0502, "t3_rd0");
    rd(8'd1, 16'h0003, "t3_rd1");
    rd(8'd2, 16'h0000, "t3_rd2");

    // 256-word load via length byte 00
    d0 = done_cnt;
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      drive(1'b0, 1'b1, ~iv);
      if (i == 255) begin
        chk("t4_not_done_512", 32'(done_cnt - d0), 32'd0);
        chk("t4_cpu_rst_512", 32'(cpu_rst), 32'd1);
      end
      drive(1'b0, 1'b1, iv);
    end
    chk("t4_done", 32'(load_done), 32'd1);
    drive(1'b0, 1'b0, 8'h00);
    chk("t4_done_once", 32'(done_cnt - d0), 32'd1);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      rd(iv, {iv, ~iv}, "t4_rd");
    end

    // restart mid-load, then 1-word load
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h04);
    drive(1'b0, 1'b1, 8'h11);
    drive(1'b0, 1'b1, 8'h22);
    drive(1'b0, 1'b1, 8'h33);
    drive(1'b1, 1'b1, 8'h44);
    chk("t5_restart_ready", 32'(load_ready), 32'd1);
    drive(1'b0, 1'b1, 8'h01);
    drive(1'b0, 1'b1, 8'hFF);
    drive(1'b0, 1'b1, 8'hAA);
    chk("t5_cpu_rst", 32'(cpu_rst), 32'd0);
    rd(8'd0, 16'hAAFF, "t5_rd0");
    rd(8'd1, 16'h0000, "t5_rd1");

    // reload from RUN, then async reset mid-HIGH
    mem_address = 8'd0;
    drive(1'b1, 1'b0, 8'h00);
    chk("t6_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("t6_ready", 32'(load_ready), 32'd1);
    chk("t6_mem_value", 32'(mem_value), 32'd0);
    drive(1'b0, 1'b1, 8'h02);
    drive(1'b0, 1'b1, 8'h10);
    drive(1'b0, 1'b1, 8'h20);
    drive(1'b0, 1'b1, 8'h30);
    load_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("t6_arst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("t6_arst_ready", 32'(load_ready), 32'd0);
    chk("t6_arst_done", 32'(load_done), 32'd0);
    #2;
    rst = 1'b1;
    drive(1'b0, 1'b1, 8'h40);
    drive(1'b0, 1'b1, 8'h99);
    chk("t6_idle_ready", 32'(load_ready), 32'd0);
    chk("t6_idle_value", 32'(mem_value), 32'd0);
    drive(1'b0, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_loader_rom.md
Name: program_loader_rom

Overview:
- Instruction store that sits directly upstream of the CPU core.
- Receives a program over a byte-serial load port and assembles bytes into 16-bit instruction words.
- Holds the CPU in reset while loading, then releases it.
- Serves mem_value combinationally from the CPU's mem_address.

Parameters:
ADDR_W, 8, word address width; DEPTH = 2**ADDR_W words
DATA_W, 16, instruction word width; fixed at 2 bytes, other values unsupported

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
load_start  input  1  begin/restart a program load
load_valid  input  1  load_byte carries a byte this cycle
load_byte  input  8  serial program byte
load_ready  output  1  block accepts a byte this cycle
load_done  output  1  one-cycle pulse when the last byte is accepted
cpu_rst  output  1  active-high reset to the CPU core
mem_address  input  ADDR_W  CPU fetch address
mem_value  output  DATA_W  instruction word at mem_address

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, cpu_rst=1, load_ready=0, load_done=0.
  - word_count=0, wr_ptr=0, low-byte holding register=0.
  - Memory array contents are not cleared.
- States: IDLE, LEN, LOW, HIGH, RUN. load_ready=1 only in LEN/LOW/HIGH. cpu_rst=0 only in RUN.
- Handshake: a byte is accepted on a posedge with load_valid && load_ready. A byte with load_valid=1 and load_ready=0 is dropped silently.
- IDLE: load_start=1 -> LEN.
- LEN, on accept:
  - target = load_byte (0 means 256 words), 9-bit.
  - wr_ptr=0, word_count=0, go to LOW.
- LOW, on accept: latch low byte, go to HIGH.
- HIGH, on accept:
  - Write {load_byte, low} to mem[wr_ptr]; wr_ptr+1; word_count+1.
  - If word_count+1 == target: pulse load_done, go to RUN. cpu_rst deasserts on that same edge.
  - Otherwise go to LOW.
- RUN: load_start=1 -> LEN. cpu_rst reasserts on that edge.
- load_start in LEN/LOW/HIGH restarts the load:
  - Go to LEN, wr_ptr=0, word_count=0.
  - A byte presented in the same cycle is ignored; load_start has priority.
- wr_ptr is ADDR_W bits. A 256-word load fills the whole array with no wrap overwrite, because target caps writes at DEPTH.
- Read path, combinational, no latency:
  - mem_value = mem[mem_address] when state==RUN and mem_address < word_count.
  - Otherwise mem_value = 16'h0000.
  - The CPU registers mem_address, so the fetch is valid by its next edge.
- Word byte order: low byte first ([7:0] = opcode/rs1/rs2/rd field), then high byte ([15:8] = value).
- load_done is 0 except on the single cycle after the final accept edge.
- rst asserted mid-load discards the load. The next load must start from load_start.

Test Plan:
- Reset with rst=0 then release -> cpu_rst=1, load_ready=0, load_done=0, mem_value=0 for mem_address=0.
- load_start; bytes 02, 02,05, 03,00 with load_valid=1 each cycle:
  - load_done pulses once; cpu_rst falls on the same edge.
  - mem_address=0 -> 16'h0502; mem_address=1 -> 16'h0003; mem_address=2 -> 16'h0000.
- Same load with load_valid toggling 1/0 every cycle -> identical memory contents; load_done is delayed but still a single pulse.
- Length byte 00 followed by 512 bytes (word i = {i[7:0], ~i[7:0]}):
  - All 256 words read back correctly.
  - load_done fires only after byte 513.
- Restart: load_start after 3 data bytes of a 4-word load, then a fresh 1-word load of 01,FF,AA:
  - mem[0]=16'hAAFF; word_count=1; mem_address=1 -> 0; cpu_rst=0.
- Reload from RUN and reset mid-load:
  - load_start in RUN -> cpu_rst=1 next edge, load_ready=1, mem_value=0.
  - rst pulsed low mid-HIGH -> state IDLE, cpu_rst=1, load_ready=0 asynchronously.
